h264_quantise: RTL and testbench

- Forward quantiser directly downstream of the 4x4 core transform.
- Consumes the transform's 14-bit zigzag-ordered coefficient stream, one coefficient per cycle, 16 per block.
- Applies H.264 scalar quantisation, |Z| = (|W|*MF + f) >> qbits, with the sign restored afterwards.
- Emits 12-bit quantised levels plus a per-block nonzero count for the downstream entropy coder.

---
 rtl/h264_quantise_pkg.sv | 60 ++++++
 rtl/h264_qp_div6.sv | 23 ++
 rtl/h264_quantise.sv | 164 ++++++++++++++++
 tb/tb_h264_quantise.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/h264_quantise_pkg.sv
// Shared constants for the H.264 forward quantiser: MF and rounding-offset
// tables, QP clamp limit and the zigzag-position class lookup.
package h264_quantise_pkg;

  localparam int QP_MAX = 51;
  localparam int MF_W   = 14;
  localparam int F_W    = 22;

  typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} pos_class_t;

  function automatic pos_class_t idx_class(input logic [3:0] idx);
    pos_class_t cls;
    case (idx)
      4'd0, 4'd3, 4'd5, 4'd11:   cls = CLS_A;
      4'd4, 4'd10, 4'd12, 4'd15: cls = CLS_B;
      default:                   cls = CLS_C;
    endcase
    return cls;
  endfunction

  function automatic logic [MF_W-1:0] mf_lookup(input logic [2:0] rem, input pos_class_t cls);
    logic [MF_W-1:0] mf_a;
    logic [MF_W-1:0] mf_b;
    logic [MF_W-1:0] mf_c;
    logic [MF_W-1:0] mf;
    case (rem)
      3'd0:    begin mf_a = 14'd13107; mf_b = 14'd5243; mf_c = 14'd8066; end
      3'd1:    begin mf_a = 14'd11916; mf_b = 14'd4660; mf_c = 14'd7490; end
      3'd2:    begin mf_a = 14'd10082; mf_b = 14'd4194; mf_c = 14'd6554; end
      3'd3:    begin mf_a = 14'd9362;  mf_b = 14'd3647; mf_c = 14'd5825; end
      3'd4:    begin mf_a = 14'd8192;  mf_b = 14'd3355; mf_c = 14'd5243; end
      default: begin mf_a = 14'd7282;  mf_b = 14'd2893; mf_c = 14'd4559; end
    endcase
    case (cls)
      CLS_A:   mf = mf_a;
      CLS_B:   mf = mf_b;
      default: mf = mf_c;
    endcase
    return mf;
  endfunction

  // Rounding offset floor(2^(15+div)/3) for intra, floor(2^(15+div)/6) for inter.
  function automatic logic [F_W-1:0] f_lookup(input logic [3:0] div, input logic intra);
    logic [F_W-1:0] f_intra;
    logic [F_W-1:0] f_inter;
    case (div)
      4'd0:    begin f_intra = 22'd10922;   f_inter = 22'd5461;    end
      4'd1:    begin f_intra = 22'd21845;   f_inter = 22'd10922;   end
      4'd2:    begin f_intra = 22'd43690;   f_inter = 22'd21845;   end
      4'd3:    begin f_intra = 22'd87381;   f_inter = 22'd43690;   end
      4'd4:    begin f_intra = 22'd174762;  f_inter = 22'd87381;   end
      4'd5:    begin f_intra = 22'd349525;  f_inter = 22'd174762;  end
      4'd6:    begin f_intra = 22'd699050;  f_inter = 22'd349525;  end
      4'd7:    begin f_intra = 22'd1398101; f_inter = 22'd699050;  end
      default: begin f_intra = 22'd2796202; f_inter = 22'd1398101; end
    endcase
    return intra ? f_intra : f_inter;
  endfunction

endpackage

// File: rtl/h264_qp_div6.sv
// Combinational QP clamp (to 51) and split into {QP/6, QP%6}.
module h264_qp_div6
  import h264_quantise_pkg::*;
(
  input  logic [5:0] qp,
  output logic [3:0] qp_div6,
  output logic [2:0] qp_mod6
);

  logic [5:0]  qp_clamped;
  logic [11:0] scaled;
  logic [5:0]  base;

  // x*43>>8 equals x/6 exactly for every x in 0..51.
  always_comb begin
    qp_clamped = (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
    scaled     = {6'd0, qp_clamped} * 12'd43;
    qp_div6    = scaled[11:8];
    base       = {2'd0, qp_div6} * 6'd6;
    qp_mod6    = 3'(qp_clamped - base);
  end

endmodule

// File: rtl/h264_quantise.sv
// Three-stage H.264 forward quantiser with per-block nonzero count.
// Optional macro H264_QUANTISE_SKIPDC_EN adds SKIPDC to zero out index 0.
module h264_quantise
  import h264_quantise_pkg::*;
#(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [IN_W-1:0]  YNIN,
  input  logic [5:0]       QP,
  input  logic             INTRA,
`ifdef H264_QUANTISE_SKIPDC_EN
  input  logic             SKIPDC,
`endif
  output logic             VALID,
  output logic [OUT_W-1:0] ZOUT,
  output logic [3:0]       ZIDX,
  output logic             DONE,
  output logic [4:0]       NZCOUNT
);

  localparam int P_W = IN_W + MF_W;
  localparam int SAT = (1 << (OUT_W - 1)) - 1;

  logic [3:0]       cnt_reg;
  logic [5:0]       blk_qp_reg;
  logic             blk_intra_reg;

  logic             first;
  logic [5:0]       qp_eff;
  logic             intra_eff;
  logic             skip_now;
  logic [3:0]       qdiv;
  logic [2:0]       qmod;
  logic             neg_w;
  logic [IN_W-1:0]  abs_w;

  logic             s1_valid_reg, s1_neg_reg, s1_skip_reg;
  logic [IN_W-1:0]  s1_abs_reg;
  logic [MF_W-1:0]  s1_mf_reg;
  logic [4:0]       s1_qbits_reg;
  logic [F_W-1:0]   s1_f_reg;
  logic [3:0]       s1_idx_reg;

  logic             s2_valid_reg, s2_neg_reg, s2_skip_reg;
  logic [P_W-1:0]   s2_p_reg;
  logic [4:0]       s2_qbits_reg;
  logic [3:0]       s2_idx_reg;

  logic [P_W-1:0]   m_shift;
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] level;
  logic [4:0]       nz_inc;

  logic             valid_reg, done_reg;
  logic [OUT_W-1:0] zout_reg;
  logic [3:0]       zidx_reg;
  logic [4:0]       nzcount_reg, acc_reg;

  // Index 0 uses the live QP/INTRA; later indices use the block's latched copy.
  assign first     = (cnt_reg == 4'd0);
  assign qp_eff    = first ? QP : blk_qp_reg;
  assign intra_eff = first ? INTRA : blk_intra_reg;

`ifdef H264_QUANTISE_SKIPDC_EN
  // SKIPDC only affects index 0, where the live value is the latched one.
  assign skip_now = first & SKIPDC;
`else
  assign skip_now = 1'b0;
`endif

  h264_qp_div6 u_qp_div6 (
    .qp      (qp_eff),
    .qp_div6 (qdiv),
    .qp_mod6 (qmod)
  );

  assign neg_w = YNIN[IN_W-1];
  assign abs_w = neg_w ? IN_W'(-YNIN) : YNIN;

  always_comb begin
    m_shift = s2_p_reg >> s2_qbits_reg;
    mag     = (m_shift > P_W'(SAT)) ? OUT_W'(SAT) : m_shift[OUT_W-1:0];
    if (s2_skip_reg) mag = '0;
    level   = s2_neg_reg ? OUT_W'(-mag) : mag;
    nz_inc  = {4'd0, (mag != '0)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_reg       <= '0;
      blk_qp_reg    <= '0;
      blk_intra_reg <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_neg_reg    <= 1'b0;
      s1_skip_reg   <= 1'b0;
      s1_abs_reg    <= '0;
      s1_mf_reg     <= '0;
      s1_qbits_reg  <= '0;
      s1_f_reg      <= '0;
      s1_idx_reg    <= '0;
      s2_valid_reg  <= 1'b0;
      s2_neg_reg    <= 1'b0;
      s2_skip_reg   <= 1'b0;
      s2_p_reg      <= '0;
      s2_qbits_reg  <= '0;
      s2_idx_reg    <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
      zout_reg      <= '0;
      zidx_reg      <= '0;
      nzcount_reg   <= '0;
      acc_reg       <= '0;
    end else begin
      if (ENABLE) begin
        cnt_reg <= cnt_reg + 4'd1;
        if (first) begin
          blk_qp_reg    <= QP;
          blk_intra_reg <= INTRA;
        end
      end

      s1_valid_reg <= ENABLE;
      s1_neg_reg   <= neg_w;
      s1_skip_reg  <= skip_now;
      s1_abs_reg   <= abs_w;
      s1_mf_reg    <= mf_lookup(qmod, idx_class(cnt_reg));
      s1_qbits_reg <= 5'd15 + {1'b0, qdiv};
      s1_f_reg     <= f_lookup(qdiv, intra_eff);
      s1_idx_reg   <= cnt_reg;

      s2_valid_reg <= s1_valid_reg;
      s2_neg_reg   <= s1_neg_reg;
      s2_skip_reg  <= s1_skip_reg;
      s2_p_reg     <= P_W'(s1_abs_reg) * P_W'(s1_mf_reg) + P_W'(s1_f_reg);
      s2_qbits_reg <= s1_qbits_reg;
      s2_idx_reg   <= s1_idx_reg;

      valid_reg <= s2_valid_reg;
      zout_reg  <= level;
      zidx_reg  <= s2_idx_reg;
      done_reg  <= 1'b0;
      if (s2_valid_reg) begin
        if (s2_idx_reg == 4'd15) begin
          nzcount_reg <= acc_reg + nz_inc;
          done_reg    <= 1'b1;
          acc_reg     <= '0;
        end else begin
          acc_reg <= acc_reg + nz_inc;
        end
      end
    end
  end

  assign VALID   = valid_reg;
  assign ZOUT    = zout_reg;
  assign ZIDX    = zidx_reg;
  assign DONE    = done_reg;
  assign NZCOUNT = nzcount_reg;

endmodule

// File: tb/tb_h264_quantise.sv
// Randomised self-checking bench for h264_quantise against an arithmetic model.
module tb_h264_quantise;

  localparam int IN_W  = 14;
  localparam int OUT_W = 12;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             ENABLE = 1'b0;
  logic [IN_W-1:0]  YNIN = '0;
  logic [5:0]       QP = '0;
  logic             INTRA = 1'b0;
  logic             skipdc = 1'b0;
  logic             VALID;
  logic [OUT_W-1:0] ZOUT;
  logic [3:0]       ZIDX;
  logic             DONE;
  logic [4:0]       NZCOUNT;

  h264_quantise #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .YNIN    (YNIN),
    .QP      (QP),
    .INTRA   (INTRA),
`ifdef H264_QUANTISE_SKIPDC_EN
    .SKIPDC  (skipdc),
`endif
    .VALID   (VALID),
    .ZOUT    (ZOUT),
    .ZIDX    (ZIDX),
    .DONE    (DONE),
    .NZCOUNT (NZCOUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int due;
    int z;
    int idx;
    bit done;
    int nz;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0;
  int   done_seen = 0, done_exp = 0;
  int   m_idx = 0, m_acc = 0;
  int   blk_qp = 0;
  bit   blk_intra = 1'b0;
  int   coef[16];
  int   mf_tab[3][6] = '{'{13107, 11916, 10082, 9362, 8192, 7282},
                         '{5243, 4660, 4194, 3647, 3355, 2893},
                         '{8066, 7490, 6554, 5825, 5243, 4559}};

  task automatic check(input string tag, input longint obs, input longint expv);
    n_total++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // |Z| = (|W|*MF + f) >> qbits, saturated, sign restored.
  function automatic int ref_level(int w, int idx, int qp, bit intra);
    int     q = (qp > 51) ? 51 : qp;
    int     qbits = 15 + q / 6;
    longint f = (longint'(1) << qbits) / (intra ? 3 : 6);
    longint a = (w < 0) ? -w : w;
    int     cls;
    longint z;
    if (idx inside {0, 3, 5, 11}) cls = 0;
    else if (idx inside {4, 10, 12, 15}) cls = 1;
    else cls = 2;
    z = (a * mf_tab[cls][q % 6] + f) >>> qbits;
    if (z > 2047) z = 2047;
    return (w < 0) ? -int'(z) : int'(z);
  endfunction

  function automatic int rand_coef();
    case ($urandom_range(3))
      0: return int'($urandom_range(16383)) - 8192;
      1: return int'($urandom_range(600)) - 300;
      2: return 0;
      default: return ($urandom_range(1) == 0) ? 8191 : -8192;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      ENABLE = 1'b0;
      YNIN   = IN_W'($urandom);
      QP     = 6'($urandom);
      INTRA  = 1'($urandom);
    end
  endtask

  task automatic drive(input int w);
    exp_t e;
    @(negedge CLK);
    ENABLE = 1'b1;
    YNIN   = IN_W'(w);
    if (m_idx == 0) begin
      QP    = 6'(blk_qp);
      INTRA = blk_intra;
    end else begin
      QP    = 6'($urandom);
      INTRA = 1'($urandom);
    end
    e.due  = cyc + 3;
    e.idx  = m_idx;
    e.z    = ref_level(w, m_idx, blk_qp, blk_intra);
    if (e.z != 0) m_acc++;
    e.done = (m_idx == 15);
    e.nz   = m_acc;
    if (e.done) begin
      m_acc = 0;
      done_exp++;
    end
    exp_q.push_back(e);
    m_idx = (m_idx + 1) % 16;
  endtask

  task automatic run_block(input int qp, input bit intra, input int maxgap);
    blk_qp    = qp;
    blk_intra = intra;
    for (int i = 0; i < 16; i++) begin
      if (maxgap > 0 && $urandom_range(2) == 0) idle(int'($urandom_range(1, maxgap)));
      drive(coef[i]);
    end
  endtask

  task automatic rand_coefs();
    for (int i = 0; i < 16; i++) coef[i] = rand_coef();
  endtask

  task automatic pulse_reset(input int n);
    @(negedge CLK);
    #1;
    RESET  = 1'b1;
    ENABLE = 1'b0;
    exp_q.delete();
    m_idx = 0;
    m_acc = 0;
    repeat (n) @(negedge CLK);
    check("rst_valid", VALID, 0);
    check("rst_done", DONE, 0);
    check("rst_nzcount", NZCOUNT, 0);
    RESET = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (VALID) begin
      if (exp_q.size() == 0 || exp_q[0].due != cyc) begin
        check("unexpected_valid", VALID, 0);
      end else begin
        e = exp_q.pop_front();
        check("zout", longint'($signed(ZOUT)), e.z);
        check("zidx", ZIDX, e.idx);
        check("done", DONE, e.done);
        if (e.done) check("nzcount", NZCOUNT, e.nz);
      end
      if (DONE) done_seen++;
    end else begin
      if (DONE) check("done_without_valid", DONE, 0);
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        check("missing_valid", VALID, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    check("reset_valid", VALID, 0);
    check("reset_zout", ZOUT, 0);
    check("reset_zidx", ZIDX, 0);
    check("reset_done", DONE, 0);
    check("reset_nzcount", NZCOUNT, 0);
    RESET = 1'b0;

    // Directed: rounding modes, sign, saturation.
    rand_coefs(); coef[0] = 100;  coef[1] = 80;  run_block(28, 1'b1, 0);
    rand_coefs(); coef[0] = -100; coef[1] = 80;  run_block(28, 1'b0, 0);
    rand_coefs(); coef[0] = 8191; coef[5] = -8192; run_block(0, 1'b1, 0);
    rand_coefs(); coef[0] = -8192; run_block(0, 1'b1, 0);

    // All-zero block, then exactly three nonzero levels.
    for (int i = 0; i < 16; i++) coef[i] = 0;
    run_block(int'($urandom_range(63)), 1'($urandom), 0);
    coef[2] = 8000; coef[7] = -8000; coef[13] = 8000;
    run_block(20, 1'b0, 0);
    idle(6);
    check("nzcount_hold", NZCOUNT, 3);

    // Aborted partial block followed by a fresh QP=10 block.
    blk_qp = 30; blk_intra = 1'b1;
    for (int i = 0; i < 7; i++) drive(rand_coef());
    pulse_reset(1);
    rand_coefs(); run_block(10, 1'($urandom), 0);

    // Back-to-back blocks with gaps in the first one.
    rand_coefs(); run_block(0, 1'b1, 3);
    rand_coefs(); run_block(51, 1'b0, 0);

    repeat (20) begin
      rand_coefs();
      run_block(int'($urandom_range(63)), 1'($urandom), int'($urandom_range(2)));
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) idle(1);
    check("drain_empty", exp_q.size(), 0);
    check("done_pulses", done_seen, done_exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
